// File: rtl/warmboot_sequencer.sv
// warmboot_sequencer: USB detach, settle, then SB_WARMBOOT into a selectable iCE40 image
module warmboot_sequencer #(
  parameter int                      IMAGE_W       = 2,
  parameter logic [2**IMAGE_W-1:0]   IMAGE_MASK    = 4'hE,
  parameter int                      DETACH_CYCLES = 12000,
  parameter int                      SETTLE_CYCLES = 1200
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               boot_req_i,
  input  logic [IMAGE_W-1:0] boot_image_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               req_err_o,
  output logic               usb_pu_o,
  output logic               usb_tx_inh_o,
  output logic [IMAGE_W-1:0] wb_s_o,
  output logic               wb_boot_o
);
  localparam int MAX_CYCLES = DETACH_CYCLES > SETTLE_CYCLES ? DETACH_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] D_LD = CW'(DETACH_CYCLES - 1);
  localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DETACH, SETTLE, BOOT} state_e;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IMAGE_W-1:0] wb_s_q, wb_s_d;
  logic               req_err_q, req_err_d;
  logic               busy_q, usb_pu_q, usb_tx_inh_q, wb_boot_q;
  // Next state: accept/reject requests in IDLE, count down each timed phase, abort back to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_s_d    = wb_s_q;
    req_err_d = 1'b0;
    case (state_q)
      IDLE: if (boot_req_i) begin
        if (IMAGE_MASK[boot_image_i]) begin
          state_d = DETACH;
          cnt_d   = D_LD;
          wb_s_d  = boot_image_i;
        end else begin
          req_err_d = 1'b1;
        end
      end
      DETACH, SETTLE: if (abort_i) begin
        state_d = IDLE;
        cnt_d   = '0;
        wb_s_d  = '0;
      end else if (cnt_q == '0) begin
        state_d = state_q == DETACH ? SETTLE : BOOT;
        cnt_d   = state_q == DETACH ? S_LD : '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end
  // State, counter and registered outputs decoded from the next state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_s_q       <= '0;
      req_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      usb_pu_q     <= 1'b1;
      usb_tx_inh_q <= 1'b0;
      wb_boot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_s_q       <= wb_s_d;
      req_err_q    <= req_err_d;
      busy_q       <= state_d != IDLE;
      usb_pu_q     <= state_d == IDLE;
      usb_tx_inh_q <= state_d != IDLE;
      wb_boot_q    <= state_d == BOOT;
    end
  end
  assign busy_o       = busy_q;
  assign req_err_o    = req_err_q;
  assign usb_pu_o     = usb_pu_q;
  assign usb_tx_inh_o = usb_tx_inh_q;
  assign wb_s_o       = wb_s_q;
  assign wb_boot_o    = wb_boot_q;
endmodule
